reg_ex_ma_skid: RTL and testbench

- Parametrised EX/MA pipeline boundary register with valid/ready handshake and a 2-entry skid buffer.
- Sits between the execute stage (ALU, effective-address generation) and the memory-access stage.
- Adds stall, flush and bubble semantics so memory-stage backpressure never forms a combinational path back into execute.
- Carries the same EX→MA payload: PC-mux control, ALU result, effective address, memory-op flags, rd/rt, ALU-destination select.

---
 rtl/reg_ex_ma_skid_if.sv | 51 +++++
 rtl/reg_ex_ma_skid.sv | 132 +++++++++++++
 tb/tb_reg_ex_ma_skid.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/reg_ex_ma_skid_if.sv
// EX->MA boundary bundle: execute-side inputs (i_*) and memory-side outputs (o_*).
// The block uses the slave view and the execute/memory stages use the master view.
interface reg_ex_ma_skid_if #(
  parameter int NBITS  = 32,
  parameter int REG_AW = 5,
  parameter int DST_W  = 2
);
  logic              i_valid;
  logic              o_ready;
  logic              i_flush;
  logic              i_pc_mux_ctrl;
  logic [NBITS-1:0]  i_ALU_rslt;
  logic [NBITS-1:0]  i_eff_addr;
  logic              i_flg_mem_op;
  logic              i_flg_mem_type;
  logic [1:0]        i_flg_mem_size;
  logic              i_flg_unsign;
  logic [REG_AW-1:0] i_rd;
  logic [REG_AW-1:0] i_rt;
  logic [DST_W-1:0]  i_flg_ALU_dst;
  logic              o_valid;
  logic              i_ready;
  logic              o_pc_mux_ctrl;
  logic [NBITS-1:0]  o_ALU_rslt;
  logic [NBITS-1:0]  o_eff_addr;
  logic              o_flg_mem_op;
  logic              o_flg_mem_type;
  logic [1:0]        o_flg_mem_size;
  logic              o_flg_unsign;
  logic [REG_AW-1:0] o_rd;
  logic [REG_AW-1:0] o_rt;
  logic [DST_W-1:0]  o_flg_ALU_dst;

  modport slave (
    input  i_valid, i_flush, i_ready, i_pc_mux_ctrl, i_ALU_rslt, i_eff_addr,
           i_flg_mem_op, i_flg_mem_type, i_flg_mem_size, i_flg_unsign,
           i_rd, i_rt, i_flg_ALU_dst,
    output o_ready, o_valid, o_pc_mux_ctrl, o_ALU_rslt, o_eff_addr,
           o_flg_mem_op, o_flg_mem_type, o_flg_mem_size, o_flg_unsign,
           o_rd, o_rt, o_flg_ALU_dst
  );

  modport master (
    output i_valid, i_flush, i_ready, i_pc_mux_ctrl, i_ALU_rslt, i_eff_addr,
           i_flg_mem_op, i_flg_mem_type, i_flg_mem_size, i_flg_unsign,
           i_rd, i_rt, i_flg_ALU_dst,
    input  o_ready, o_valid, o_pc_mux_ctrl, o_ALU_rslt, o_eff_addr,
           o_flg_mem_op, o_flg_mem_type, o_flg_mem_size, o_flg_unsign,
           o_rd, o_rt, o_flg_ALU_dst
  );
endinterface

// File: rtl/reg_ex_ma_skid.sv
// EX/MA pipeline register with a 2-entry skid buffer; o_ready is registered so MA stalls never reach EX.
// Define REG_EX_MA_STATS_EN to add saturating stall/flush counters (o_stall_cnt, o_flush_cnt).
module reg_ex_ma_skid #(
  parameter int NBITS  = 32,
  parameter int REG_AW = 5,
  parameter int DST_W  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
`ifdef REG_EX_MA_STATS_EN
  output logic [15:0]          o_stall_cnt,
  output logic [15:0]          o_flush_cnt,
`endif
  reg_ex_ma_skid_if.slave      bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic              pc_mux_ctrl;
    logic [NBITS-1:0]  alu_rslt;
    logic [NBITS-1:0]  eff_addr;
    logic              mem_op;
    logic              mem_type;
    logic [1:0]        mem_size;
    logic              unsign;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rt;
    logic [DST_W-1:0]  alu_dst;
  } payload_t;

  state_e   state_q, state_d;
  payload_t main_q, main_d, skid_q, skid_d, in_pl;
  logic     rdy_q, rdy_d;
  logic     valid, accept, pop;

  assign in_pl = '{pc_mux_ctrl: bus.i_pc_mux_ctrl, alu_rslt: bus.i_ALU_rslt,
                   eff_addr: bus.i_eff_addr, mem_op: bus.i_flg_mem_op,
                   mem_type: bus.i_flg_mem_type, mem_size: bus.i_flg_mem_size,
                   unsign: bus.i_flg_unsign, rd: bus.i_rd, rt: bus.i_rt,
                   alu_dst: bus.i_flg_ALU_dst};

  assign valid  = (state_q != EMPTY);
  assign accept = bus.i_valid & rdy_q;
  assign pop    = valid & bus.i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          main_d  = in_pl;
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_pl;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_pl;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
    // ready is a function of next state only, so it never depends on i_ready combinationally
    rdy_d = (state_d != TWO);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.o_ready        = rdy_q;
  assign bus.o_valid        = valid;
  // side-effecting controls are gated so a bubble can never write PC, memory or a register
  assign bus.o_pc_mux_ctrl  = valid & main_q.pc_mux_ctrl;
  assign bus.o_flg_mem_op   = valid & main_q.mem_op;
  assign bus.o_flg_ALU_dst  = valid ? main_q.alu_dst : '0;
  assign bus.o_ALU_rslt     = main_q.alu_rslt;
  assign bus.o_eff_addr     = main_q.eff_addr;
  assign bus.o_flg_mem_type = main_q.mem_type;
  assign bus.o_flg_mem_size = main_q.mem_size;
  assign bus.o_flg_unsign   = main_q.unsign;
  assign bus.o_rd           = main_q.rd;
  assign bus.o_rt           = main_q.rt;

`ifdef REG_EX_MA_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (valid && !bus.i_ready && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (bus.i_flush && valid && flush_cnt_q != 16'hFFFF)  flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_reg_ex_ma_skid.sv
// Directed bench for reg_ex_ma_skid: reset, streaming, backpressure, flush, bubble gating, stats.
module tb_reg_ex_ma_skid;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_ex_ma_skid_if #(.NBITS(32), .REG_AW(5), .DST_W(2)) bus ();

`ifdef REG_EX_MA_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  reg_ex_ma_skid #(.NBITS(32), .REG_AW(5), .DST_W(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
`ifdef REG_EX_MA_STATS_EN
    .o_stall_cnt (stall_cnt),
    .o_flush_cnt (flush_cnt),
`endif
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_valid = 0; bus.i_flush = 0; bus.i_ready = 0;
    bus.i_pc_mux_ctrl = 0; bus.i_ALU_rslt = 0; bus.i_eff_addr = 0;
    bus.i_flg_mem_op = 0; bus.i_flg_mem_type = 0; bus.i_flg_mem_size = 0;
    bus.i_flg_unsign = 0; bus.i_rd = 0; bus.i_rt = 0; bus.i_flg_ALU_dst = 0;

    // reset
    #12;
    check("rst_valid", 32'(bus.o_valid), 0);
    check("rst_alu", bus.o_ALU_rslt, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 32'(bus.o_ready), 1);
    check("post_rst_valid", 32'(bus.o_valid), 0);

    // streaming
    bus.i_valid = 1; bus.i_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      bus.i_ALU_rslt = 32'(k);
      step();
      check("stream_valid", 32'(bus.o_valid), 1);
      check("stream_alu", bus.o_ALU_rslt, 32'(k));
      check("stream_ready", 32'(bus.o_ready), 1);
    end
    bus.i_valid = 0;
    step();
    check("stream_drain", 32'(bus.o_valid), 0);

    // backpressure into TWO
    bus.i_ready = 0; bus.i_valid = 1; bus.i_ALU_rslt = 32'hA;
    step();
    check("bp_a_alu", bus.o_ALU_rslt, 32'hA);
    check("bp_a_ready", 32'(bus.o_ready), 1);
    bus.i_ALU_rslt = 32'hB;
    step();
    check("bp_two_ready", 32'(bus.o_ready), 0);
    check("bp_two_alu", bus.o_ALU_rslt, 32'hA);
    bus.i_valid = 0; bus.i_ALU_rslt = 32'hEE;
    step();
    check("bp_hold_alu", bus.o_ALU_rslt, 32'hA);
    check("bp_hold_valid", 32'(bus.o_valid), 1);
    bus.i_ready = 1;
    step();
    check("bp_pop_b_alu", bus.o_ALU_rslt, 32'hB);
    check("bp_pop_b_valid", 32'(bus.o_valid), 1);
    check("bp_pop_ready", 32'(bus.o_ready), 1);
    step();
    check("bp_empty", 32'(bus.o_valid), 0);

    // flush while in TWO with an incoming instruction
    bus.i_ready = 0; bus.i_valid = 1; bus.i_ALU_rslt = 32'h1A;
    step();
    bus.i_ALU_rslt = 32'h1B;
    step();
    check("fl_two_ready", 32'(bus.o_ready), 0);
    bus.i_flush = 1; bus.i_ALU_rslt = 32'hC;
    step();
    check("fl_valid", 32'(bus.o_valid), 0);
    check("fl_ready", 32'(bus.o_ready), 1);
    bus.i_flush = 0; bus.i_valid = 0; bus.i_ready = 1;
    step();
    check("fl_no_c", 32'(bus.o_valid), 0);

    // bubble gating
    bus.i_valid = 0; bus.i_ready = 0;
    bus.i_flg_mem_op = 1; bus.i_flg_ALU_dst = 2'd3; bus.i_pc_mux_ctrl = 1;
    step();
    check("bub_mem_op", 32'(bus.o_flg_mem_op), 0);
    check("bub_alu_dst", 32'(bus.o_flg_ALU_dst), 0);
    check("bub_pc_mux", 32'(bus.o_pc_mux_ctrl), 0);
    bus.i_valid = 1; bus.i_ALU_rslt = 32'h55; bus.i_eff_addr = 32'h1000;
    bus.i_rd = 5'd7; bus.i_rt = 5'd9; bus.i_flg_mem_size = 2'd2;
    bus.i_flg_mem_type = 1; bus.i_flg_unsign = 1;
    step();
    bus.i_valid = 0;
    check("pl_mem_op", 32'(bus.o_flg_mem_op), 1);
    check("pl_alu_dst", 32'(bus.o_flg_ALU_dst), 3);
    check("pl_pc_mux", 32'(bus.o_pc_mux_ctrl), 1);
    check("pl_eff_addr", bus.o_eff_addr, 32'h1000);
    check("pl_rd", 32'(bus.o_rd), 7);
    check("pl_rt", 32'(bus.o_rt), 9);
    check("pl_size", 32'(bus.o_flg_mem_size), 2);
    check("pl_type_uns", {30'd0, bus.o_flg_mem_type, bus.o_flg_unsign}, 32'd3);

    // reset mid-transfer discards the held entry at once
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.o_valid), 0);
    check("midrst_alu", bus.o_ALU_rslt, 0);
    check("midrst_mem_op", 32'(bus.o_flg_mem_op), 0);
    #3 rst_n = 1'b1;
    step();
    check("midrst_ready", 32'(bus.o_ready), 1);
    check("midrst_empty", 32'(bus.o_valid), 0);

`ifdef REG_EX_MA_STATS_EN
    check("st_stall0", 32'(stall_cnt), 0);
    bus.i_valid = 1; bus.i_ready = 0; bus.i_ALU_rslt = 32'h5;
    step();
    bus.i_valid = 0;
    repeat (3) step();
    check("st_stall3", 32'(stall_cnt), 3);
    bus.i_flush = 1; bus.i_ready = 1;
    step();
    bus.i_flush = 0;
    check("st_stall_after", 32'(stall_cnt), 3);
    check("st_flush1", 32'(flush_cnt), 1);
    bus.i_flush = 1;
    step();
    bus.i_flush = 0;
    check("st_flush_empty", 32'(flush_cnt), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
